lane_skew_channel: RTL and testbench
====================================

# lane_skew_channel

Runtime-programmable multi-lane block-skew generator for the PCS channel model. It sits between the bit-skew stage and the RX top level. Each of N_LANES 66-bit lanes is delayed by a per-lane number of valid words, reprogrammable at run time through register-file pulses, so deskew can be exercised without rebuilding. It also reports per-lane fill status and the current lane-to-lane skew spread.

## Interface
Parameters:
- N_LANES, 20, lane count
- NB_DATA_CODED, 66, bits per coded block
- MAX_DELAY, 16, maximum per-lane delay in valid words
- NB_DELAY, $clog2(MAX_DELAY+1), delay field width
- NB_DATA_BUS, N_LANES*NB_DATA_CODED, bus width

Ports:
- i_clock  in  1  single clock
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  input word strobe, common to all lanes
- i_data  in  NB_DATA_BUS  lane k at [NB_DATA_BUS-1-k*NB_DATA_CODED -: NB_DATA_CODED]
- i_aligner_tag  in  N_LANES  per-lane tag; lane k at bit N_LANES-1-k
- i_rf_delay  in  NB_DELAY  delay value to load
- i_rf_update  in  N_LANES  per-lane load pulse; lane k at bit N_LANES-1-k
- o_data  out  NB_DATA_BUS  delayed data, same slicing as i_data
- o_aligner_tag  out  N_LANES  delayed tags
- o_valid  out  1  registered i_valid
- o_lane_filled  out  N_LANES  lane k is emitting true delayed data
- o_rf_max_skew  out  NB_DELAY  max(delay) minus min(delay) across lanes

## Operation
- Write pointer wr_ptr is shared by all lanes and covers 0..MAX_DELAY-1.
  - On i_valid, each lane writes {tag, data} to mem[wr_ptr].
  - wr_ptr then increments and wraps from MAX_DELAY-1 to 0.
- Per-lane read behaviour:
  - delay 0: the lane outputs the current input word.
  - otherwise: the lane outputs mem[(wr_ptr - delay) mod MAX_DELAY].
  - Read happens before write, so delay MAX_DELAY returns the entry being overwritten.
- Output update: o_data and o_aligner_tag are registered and update only on i_valid. They hold while i_valid is low.
- Update:
  - i_rf_update[k] loads delay[k] from i_rf_delay; values above MAX_DELAY saturate to MAX_DELAY.
  - The lane's fill counter is cleared.
  - Other lanes are unaffected.
- Fill tracking:
  - The fill counter increments on each i_valid and saturates at MAX_DELAY.
  - o_lane_filled[k] = (fill_cnt[k] >= delay[k]), registered.
- Simultaneous update and i_valid: the write happens, and that cycle's output uses the old delay. The fill counter goes to 0 and that word is not counted.
- o_rf_max_skew is recomputed, registered, from the delay registers.

## Timing
- Reset values:
  - o_data = 0, o_aligner_tag = 0, o_valid = 0, o_rf_max_skew = 0, o_lane_filled = all ones.
  - All delays = 0, wr_ptr = 0, memories = 0, fill counters = 0.
- Latency:
  - o_valid: 1 cycle after i_valid.
  - Lane k data: 1 cycle plus delay[k] valid words.
- o_lane_filled[k]:
  - Low the cycle after an update with nonzero delay.
  - High again the cycle after the delay[k]-th subsequent valid word.
  - A delay-0 update leaves it high.
- o_rf_max_skew is valid 2 cycles after the update pulse.
- Reset asserted mid-stream clears everything asynchronously. Programmed delays are lost.

## Configuration
- LANE_SKEW_FLUSH_EN defined:
  - While o_lane_filled[k] is low, lane k's o_data slice and tag are forced to 0.
- LANE_SKEW_FLUSH_EN undefined:
  - Stale buffer contents pass through unmasked.
  - o_lane_filled is still generated.

## Structure
- Package pcs_channel_pkg holds:
  - N_LANES, NB_DATA_CODED and MAX_DELAY defaults.
  - A lane-slice helper for MSB-first bus indexing.
- Sub-module lane_delay_line, generated once per lane, contains the memory, delay register, fill counter and output mux.
- wr_ptr and the max/min skew reduction live in the top.

## Test plan
- Reset, then 10 valid words with incrementing data:
  - Every lane's o_data equals its input one cycle later.
  - o_lane_filled = all ones; o_rf_max_skew = 0.
- i_rf_update on lane 3 with i_rf_delay = 5:
  - o_lane_filled[3] is low for 5 valid words and lane 3 is zero (flush build).
  - Lane 3 then shows the word from 5 valid words earlier.
  - o_rf_max_skew = 5.
- i_rf_delay = 20 on lane 0:
  - Saturates to 16; lane 0 lags exactly 16 words across several wr_ptr wraps.
  - o_rf_max_skew = 16.
- i_valid alternating 1/0 with lane 2 delay 4:
  - Lag is 4 valid words (about 8 cycles).
  - Outputs hold during invalid cycles.
- Update on lanes 0 and 19 coincident with i_valid:
  - The output on that cycle uses the old delay.
  - Fill counting starts from the next valid word.
- Reset mid-stream with delays programmed:
  - All outputs go to their reset values immediately.
  - After release, all lanes pass through with delay 0.

Source files
------------

// File: rtl/pcs_channel_pkg.sv
// Shared defaults and lane-slicing helpers for the PCS channel model.
// Buses carry lane 0 in the most significant slice.
package pcs_channel_pkg;

  localparam int N_LANES_DEF       = 20;
  localparam int NB_DATA_CODED_DEF = 66;
  localparam int MAX_DELAY_DEF     = 16;

  // LSB position of a lane's slice in an MSB-first packed bus
  function automatic int lane_lsb(input int lane, input int n_lanes, input int nb_lane);
    return (n_lanes - 1 - lane) * nb_lane;
  endfunction

  // Bit position of a lane's flag in an MSB-first per-lane vector
  function automatic int lane_bit(input int lane, input int n_lanes);
    return n_lanes - 1 - lane;
  endfunction

endpackage

// File: rtl/lane_delay_line.sv
// Single-lane programmable block delay: ring memory written at a shared
// pointer, per-lane delay register, fill counter and registered output.
// Optional feature macro: LANE_SKEW_FLUSH_EN (mask output until filled).
module lane_delay_line #(
  parameter int NB_DATA_CODED = 66,
  parameter int MAX_DELAY     = 16,
  parameter int NB_DELAY      = $clog2(MAX_DELAY + 1),
  parameter int NB_PTR        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [NB_DATA_CODED-1:0] i_data,
  input  logic                     i_tag,
  input  logic [NB_PTR-1:0]        i_wr_ptr,
  input  logic [NB_DELAY-1:0]      i_rf_delay,
  input  logic                     i_rf_update,
  output logic [NB_DATA_CODED-1:0] o_data,
  output logic                     o_tag,
  output logic                     o_filled,
  output logic [NB_DELAY-1:0]      o_delay
);

  localparam int                  NB_WORD = NB_DATA_CODED + 1;
  localparam logic [NB_PTR:0]     MAX_W   = (NB_PTR + 1)'(MAX_DELAY);
  localparam logic [NB_DELAY-1:0] MAX_D   = NB_DELAY'(MAX_DELAY);

  logic [NB_WORD-1:0]  mem [MAX_DELAY];
  logic [NB_DELAY-1:0] delay_q, delay_d;
  logic [NB_DELAY-1:0] fill_q, fill_d;
  logic [NB_PTR:0]     rd_sum;
  logic [NB_PTR-1:0]   rd_idx;
  logic [NB_WORD-1:0]  word_p0;
  logic [NB_WORD-1:0]  word_p1;
  logic                filled_p1;

  function automatic logic [NB_DELAY-1:0] sat_delay(input logic [NB_DELAY-1:0] v);
    return (v > MAX_D) ? MAX_D : v;
  endfunction

  // Next delay/fill state; an update wins over counting the same-cycle word
  always_comb begin
    delay_d = delay_q;
    fill_d  = fill_q;
    if (i_rf_update) begin
      delay_d = sat_delay(i_rf_delay);
      fill_d  = '0;
    end else if (i_valid && (fill_q < MAX_D)) begin
      fill_d = fill_q + NB_DELAY'(1);
    end
  end

  // Read index (wr_ptr - delay) mod MAX_DELAY and output word select
  always_comb begin
    rd_sum = {1'b0, i_wr_ptr} + MAX_W - (NB_PTR + 1)'(delay_q);
    rd_idx = (rd_sum >= MAX_W) ? NB_PTR'(rd_sum - MAX_W) : NB_PTR'(rd_sum);
    word_p0 = (delay_q == '0) ? {i_tag, i_data} : mem[rd_idx];
  end

  // Ring memory: read above sees the old entry before this write lands
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < MAX_DELAY; i++) mem[i] <= '0;
    end else if (i_valid) begin
      mem[i_wr_ptr] <= {i_tag, i_data};
    end
  end

  // Delay register, fill counter, filled flag and output word
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      delay_q   <= '0;
      fill_q    <= '0;
      filled_p1 <= 1'b1;
      word_p1   <= '0;
    end else begin
      delay_q   <= delay_d;
      fill_q    <= fill_d;
      filled_p1 <= (fill_d >= delay_d);
      if (i_valid) word_p1 <= word_p0;
    end
  end

`ifdef LANE_SKEW_FLUSH_EN
  assign o_data = filled_p1 ? word_p1[NB_DATA_CODED-1:0] : '0;
  assign o_tag  = filled_p1 & word_p1[NB_DATA_CODED];
`else
  assign o_data = word_p1[NB_DATA_CODED-1:0];
  assign o_tag  = word_p1[NB_DATA_CODED];
`endif

  assign o_filled = filled_p1;
  assign o_delay  = delay_q;

endmodule

// File: rtl/lane_skew_channel.sv
// Multi-lane runtime-programmable block-skew generator. Owns the shared
// write pointer and the lane-to-lane skew spread; one delay line per lane.
// Optional feature macro: LANE_SKEW_FLUSH_EN (handled in lane_delay_line).
module lane_skew_channel
  import pcs_channel_pkg::*;
#(
  parameter int N_LANES       = N_LANES_DEF,
  parameter int NB_DATA_CODED = NB_DATA_CODED_DEF,
  parameter int MAX_DELAY     = MAX_DELAY_DEF,
  parameter int NB_DELAY      = $clog2(MAX_DELAY + 1),
  parameter int NB_DATA_BUS   = N_LANES * NB_DATA_CODED
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_DATA_BUS-1:0] i_data,
  input  logic [N_LANES-1:0]     i_aligner_tag,
  input  logic [NB_DELAY-1:0]    i_rf_delay,
  input  logic [N_LANES-1:0]     i_rf_update,
  output logic [NB_DATA_BUS-1:0] o_data,
  output logic [N_LANES-1:0]     o_aligner_tag,
  output logic                   o_valid,
  output logic [N_LANES-1:0]     o_lane_filled,
  output logic [NB_DELAY-1:0]    o_rf_max_skew
);

  localparam int                NB_PTR   = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [NB_PTR-1:0] PTR_LAST = NB_PTR'(MAX_DELAY - 1);

  logic [NB_PTR-1:0]   wr_ptr;
  logic                vld_p1;
  logic [NB_DELAY-1:0] lane_delay [N_LANES];
  logic [NB_DELAY-1:0] skew_hi, skew_lo;
  logic [NB_DELAY-1:0] skew_p1;

  // Shared write pointer, advances once per valid word
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
    end else if (i_valid) begin
      wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + NB_PTR'(1);
    end
  end

  // Output strobe follows the input strobe by one cycle
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) vld_p1 <= 1'b0;
    else          vld_p1 <= i_valid;
  end

  genvar k;
  generate
    for (k = 0; k < N_LANES; k++) begin : g_lane
      localparam int LSB = lane_lsb(k, N_LANES, NB_DATA_CODED);
      localparam int BIT = lane_bit(k, N_LANES);

      lane_delay_line #(
        .NB_DATA_CODED (NB_DATA_CODED),
        .MAX_DELAY     (MAX_DELAY),
        .NB_DELAY      (NB_DELAY),
        .NB_PTR        (NB_PTR)
      ) u_line (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_data      (i_data[LSB +: NB_DATA_CODED]),
        .i_tag       (i_aligner_tag[BIT]),
        .i_wr_ptr    (wr_ptr),
        .i_rf_delay  (i_rf_delay),
        .i_rf_update (i_rf_update[BIT]),
        .o_data      (o_data[LSB +: NB_DATA_CODED]),
        .o_tag       (o_aligner_tag[BIT]),
        .o_filled    (o_lane_filled[BIT]),
        .o_delay     (lane_delay[k])
      );
    end
  endgenerate

  // Largest and smallest programmed delay across all lanes
  always_comb begin
    skew_hi = '0;
    skew_lo = '1;
    for (int i = 0; i < N_LANES; i++) begin
      if (lane_delay[i] > skew_hi) skew_hi = lane_delay[i];
      if (lane_delay[i] < skew_lo) skew_lo = lane_delay[i];
    end
  end

  // Registered skew spread
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) skew_p1 <= '0;
    else          skew_p1 <= skew_hi - skew_lo;
  end

  assign o_valid       = vld_p1;
  assign o_rf_max_skew = skew_p1;

endmodule

// File: tb/tb_lane_skew_channel.sv
// Scoreboard bench for lane_skew_channel: a history-based reference model
// predicts each cycle's outputs when stimulus is driven; a monitor compares.
module tb_lane_skew_channel;

  localparam int N_LANES       = 20;
  localparam int NB_DATA_CODED = 66;
  localparam int MAX_DELAY     = 16;
  localparam int NB_DELAY      = $clog2(MAX_DELAY + 1);
  localparam int NB_DATA_BUS   = N_LANES * NB_DATA_CODED;

  logic                   i_clock = 1'b0;
  logic                   i_reset;
  logic                   i_valid;
  logic [NB_DATA_BUS-1:0] i_data;
  logic [N_LANES-1:0]     i_aligner_tag;
  logic [NB_DELAY-1:0]    i_rf_delay;
  logic [N_LANES-1:0]     i_rf_update;
  logic [NB_DATA_BUS-1:0] o_data;
  logic [N_LANES-1:0]     o_aligner_tag;
  logic                   o_valid;
  logic [N_LANES-1:0]     o_lane_filled;
  logic [NB_DELAY-1:0]    o_rf_max_skew;

  lane_skew_channel #(
    .N_LANES       (N_LANES),
    .NB_DATA_CODED (NB_DATA_CODED),
    .MAX_DELAY     (MAX_DELAY)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .i_aligner_tag (i_aligner_tag),
    .i_rf_delay    (i_rf_delay),
    .i_rf_update   (i_rf_update),
    .o_data        (o_data),
    .o_aligner_tag (o_aligner_tag),
    .o_valid       (o_valid),
    .o_lane_filled (o_lane_filled),
    .o_rf_max_skew (o_rf_max_skew)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic                   vld;
    logic [NB_DATA_BUS-1:0] d;
    logic [N_LANES-1:0]     t;
    logic [N_LANES-1:0]     f;
    logic [NB_DELAY-1:0]    s;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  logic [NB_DATA_BUS-1:0] hist_d[$];
  logic [N_LANES-1:0]     hist_t[$];
  int                     m_delay [N_LANES];
  int                     m_fill  [N_LANES];
  logic [N_LANES-1:0]     m_filled;
  logic [NB_DATA_BUS-1:0] m_out_d;
  logic [N_LANES-1:0]     m_out_t;
  int                     word_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_LANES-1:0] lane_mask(input int k);
    return N_LANES'(1) << (N_LANES - 1 - k);
  endfunction

  function automatic logic [NB_DATA_BUS-1:0] mk_bus(input int cnt);
    logic [NB_DATA_BUS-1:0] b;
    b = '0;
    for (int k = 0; k < N_LANES; k++)
      b[NB_DATA_BUS-1-k*NB_DATA_CODED -: NB_DATA_CODED] =
        {2'b10, 32'(cnt), 16'(k * 257 + 1), 16'h5a3c};
    return b;
  endfunction

  task automatic model_reset();
    hist_d.delete();
    hist_t.delete();
    for (int k = 0; k < N_LANES; k++) begin
      m_delay[k] = 0;
      m_fill[k]  = 0;
    end
    m_filled = '1;
    m_out_d  = '0;
    m_out_t  = '0;
    sb.delete();
  endtask

  // drive one cycle of stimulus and push the prediction for the next edge
  task automatic step(input logic v, input logic [N_LANES-1:0] upd, input int rfd);
    logic [NB_DATA_BUS-1:0] d;
    logic [N_LANES-1:0]     t;
    exp_t                   e;
    int                     hi, lo, pos, dl, b;
    @(negedge i_clock);
    d = mk_bus(word_cnt);
    t = N_LANES'($urandom);
    word_cnt++;
    i_valid       = v;
    i_data        = d;
    i_aligner_tag = t;
    i_rf_delay    = NB_DELAY'(rfd);
    i_rf_update   = upd;
    hi = 0;
    lo = MAX_DELAY;
    for (int k = 0; k < N_LANES; k++) begin
      if (m_delay[k] > hi) hi = m_delay[k];
      if (m_delay[k] < lo) lo = m_delay[k];
    end
    e.s   = NB_DELAY'(hi - lo);
    e.vld = v;
    if (v) begin
      for (int k = 0; k < N_LANES; k++) begin
        pos = NB_DATA_BUS - 1 - k * NB_DATA_CODED;
        b   = N_LANES - 1 - k;
        dl  = m_delay[k];
        if (dl == 0) begin
          m_out_d[pos -: NB_DATA_CODED] = d[pos -: NB_DATA_CODED];
          m_out_t[b] = t[b];
        end else if (hist_d.size() >= dl) begin
          m_out_d[pos -: NB_DATA_CODED] = hist_d[dl-1][pos -: NB_DATA_CODED];
          m_out_t[b] = hist_t[dl-1][b];
        end else begin
          m_out_d[pos -: NB_DATA_CODED] = '0;
          m_out_t[b] = 1'b0;
        end
      end
      hist_d.push_front(d);
      hist_t.push_front(t);
      if (hist_d.size() > MAX_DELAY + 2) begin
        void'(hist_d.pop_back());
        void'(hist_t.pop_back());
      end
    end
    for (int k = 0; k < N_LANES; k++) begin
      b = N_LANES - 1 - k;
      if (upd[b]) begin
        m_delay[k] = (rfd > MAX_DELAY) ? MAX_DELAY : rfd;
        m_fill[k]  = 0;
      end else if (v && m_fill[k] < MAX_DELAY) begin
        m_fill[k]++;
      end
      m_filled[b] = (m_fill[k] >= m_delay[k]);
    end
    e.d = m_out_d;
    e.t = m_out_t;
`ifdef LANE_SKEW_FLUSH_EN
    for (int k = 0; k < N_LANES; k++) begin
      pos = NB_DATA_BUS - 1 - k * NB_DATA_CODED;
      b   = N_LANES - 1 - k;
      if (!m_filled[b]) begin
        e.d[pos -: NB_DATA_CODED] = '0;
        e.t[b] = 1'b0;
      end
    end
`endif
    e.f = m_filled;
    sb.push_back(e);
  endtask

  task automatic check_reset_state(input string pfx);
    for (int k = 0; k < N_LANES; k++)
      chk($sformatf("%s_lane%0d_data", pfx, k),
          o_data[NB_DATA_BUS-1-k*NB_DATA_CODED -: NB_DATA_CODED], '0);
    chk({pfx, "_tag"}, o_aligner_tag, '0);
    chk({pfx, "_valid"}, o_valid, '0);
    chk({pfx, "_filled"}, o_lane_filled, {N_LANES{1'b1}});
    chk({pfx, "_skew"}, o_rf_max_skew, '0);
  endtask

  // monitor: compare DUT outputs against the oldest pending prediction
  always @(posedge i_clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("o_valid", o_valid, mon_e.vld);
      for (int k = 0; k < N_LANES; k++)
        chk($sformatf("lane%0d_data", k),
            o_data[NB_DATA_BUS-1-k*NB_DATA_CODED -: NB_DATA_CODED],
            mon_e.d[NB_DATA_BUS-1-k*NB_DATA_CODED -: NB_DATA_CODED]);
      chk("o_aligner_tag", o_aligner_tag, mon_e.t);
      chk("o_lane_filled", o_lane_filled, mon_e.f);
      chk("o_rf_max_skew", o_rf_max_skew, mon_e.s);
    end
  end

  initial begin
    i_reset       = 1'b0;
    i_valid       = 1'b0;
    i_data        = '0;
    i_aligner_tag = '0;
    i_rf_delay    = '0;
    i_rf_update   = '0;
    model_reset();
    repeat (3) @(negedge i_clock);
    check_reset_state("rst");
    i_reset = 1'b1;

    // pass-through with all delays zero
    for (int i = 0; i < 10; i++) step(1'b1, '0, 0);

    // lane 3 delay 5
    step(1'b0, lane_mask(3), 5);
    for (int i = 0; i < 12; i++) step(1'b1, '0, 0);

    // lane 0 delay 20 saturates to 16; run across several pointer wraps
    step(1'b0, lane_mask(0), 20);
    for (int i = 0; i < 40; i++) step(1'b1, '0, 0);

    // clear lanes 0 and 3, lane 2 delay 4 with alternating valid
    step(1'b0, lane_mask(0) | lane_mask(3), 0);
    step(1'b0, lane_mask(2), 4);
    for (int i = 0; i < 24; i++) step((i % 2) == 0, '0, 0);

    // update on lanes 0 and 19 coincident with a valid word
    step(1'b1, lane_mask(0) | lane_mask(19), 3);
    for (int i = 0; i < 8; i++) step(1'b1, '0, 0);

    // randomized valid and occasional reprogramming
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0) ? lane_mask($urandom_range(0, N_LANES - 1)) : '0,
           $urandom_range(0, 20));

    // reset mid-stream with delays programmed
    step(1'b1, lane_mask(5), 7);
    for (int i = 0; i < 4; i++) step(1'b1, '0, 0);
    @(posedge i_clock);
    #3;
    i_reset = 1'b0;
    #1;
    check_reset_state("midrst");
    model_reset();
    i_valid     = 1'b0;
    i_rf_update = '0;
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, '0, 0);

    repeat (2) @(posedge i_clock);
    #2;
    chk("sb_drain", 128'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
